adc_chan_avg: RTL and testbench
===============================

Name: adc_chan_avg

Overview:
- Downstream consumer of the 8-channel 12-bit ADC interface block, in the same clock domain.
- Samples all eight channel words on a fixed-rate tick into one coherent snapshot.
- Block-averages 2^LOG2_AVG snapshots per channel and flags per-channel overcurrent against a runtime trip level.
- Feeds the indicator/display logic and the inverter protection path.

Parameters:
- CLK_DIV, 5000: clocks per sample tick (10 kHz at 50 MHz). Legal minimum is 16.
- LOG2_AVG, 4: log2 of the number of samples per average block (16).
- DW, 12: channel data width.

Ports:
- CLOCK  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- CH0..CH7  in  12 each  channel words from the ADC interface block.
- TRIP_LEVEL  in  12  overcurrent threshold, unsigned.
- CLEAR_ALARM  in  1  level-sensitive clear for all alarm bits.
- AVG0..AVG7  out  12 each  latest block average per channel.
- AVG_VALID  out  1  one-cycle strobe when new averages appear.
- ALARM  out  8  sticky per-channel overcurrent flags; bit k belongs to CHk.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - AVG0..AVG7=0, AVG_VALID=0, ALARM=0.
  - State=IDLE; tick counter, sample counter, channel index and all accumulators cleared.
  - Any partial block is discarded.
- Tick generation:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - A tick cycle is one where the counter equals CLK_DIV-1.
  - Counting starts at 0 in the first clock after reset release.
- States are IDLE, ACCUM and DUMP.
- IDLE:
  - On a tick cycle, CH0..CH7 are registered into the snapshot at the closing edge.
  - State moves to ACCUM with idx=0.
- ACCUM (8 cycles, idx 0..7):
  - Each cycle does acc[idx] += snap[idx].
  - In the same cycle, if snap[idx] > TRIP_LEVEL (strictly greater), ALARM[idx] is set at the closing edge.
  - After idx=7, the sample counter increments.
  - If the sample counter was 2^LOG2_AVG-1, go to DUMP (counter wraps to 0); otherwise go to IDLE.
- DUMP (1 cycle):
  - At the closing edge, AVGk <= acc[k] >> LOG2_AVG (floor, no rounding).
  - At the same edge, all accumulators clear and AVG_VALID is asserted.
  - AVG_VALID is high for exactly the one cycle in which the new AVG values first appear, then returns to IDLE.
  - Averages hold between strobes.
- Latency: tick cycle T → AVG_VALID visible at T+10 on a block-completing tick.
- Accumulator width is DW+LOG2_AVG. Worst case 2^LOG2_AVG × 4095 cannot overflow.
- CH inputs are read only in tick cycles. Changes in other cycles have no effect on the current sample.
- A tick cannot arrive while busy, because CLK_DIV ≥ 16 > 9-cycle processing. A tick is only acted on in IDLE.
- ALARM bits are sticky; a return below threshold does not clear them.
- CLEAR_ALARM high clears all ALARM bits at the next edge.
- If a bit is being set in the same cycle that CLEAR_ALARM is high, set wins for that bit and the other bits clear.
- TRIP_LEVEL is sampled in the compare cycle. Changes mid-block affect only later compares.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_DW=12, ADC_NCH=8.
  - State enum {IDLE, ACCUM, DUMP}.
  - The channel-index type (3 bits).
- One sub-module: adc_tick_gen.
  - Parameterised by CLK_DIV.
  - Ports: CLOCK, RESET, TICK (1-cycle pulse).
  - Reused by other rate-based indicator blocks.
- Accumulators and alarm logic stay in the top as indexed register arrays.

Test Plan (CLK_DIV=20, LOG2_AVG=2; cycle 0 = first edge after reset release):
- Constant inputs CHk=100·k+5 → ticks at cycles 19/39/59/79 → AVG_VALID high only in cycle 89, with AVGk=100·k+5 (AVG0=5, AVG7=705). Next strobe at cycle 169.
- CH0 sequence 4095,4095,4095,4094 over one block → AVG0=4094 (sum 16379 floored). All four 4095 → AVG0=4095, with no overflow.
- TRIP_LEVEL=3000:
  - CH3=3000 → ALARM=0x00.
  - CH3=3001 → ALARM=0x08 after the next tick, still 0x08 after CH3 drops to 0.
  - 1-cycle CLEAR_ALARM → 0x00.
- ALARM=0x09 with CLEAR_ALARM held high across a tick where only CH5=4000>trip → ALARM=0x20 (set wins on bit 5; bits 0 and 3 clear).
- Reset mid-block:
  - Assert RESET between clock edges after 2 ticks → all outputs 0 immediately.
  - After release, the first AVG_VALID comes at cycle 89 and averages contain only post-reset samples.
- Toggle all CH inputs every cycle except tick cycles, where they are held at 0x123 → every AVG=0x123 and no ALARM for TRIP_LEVEL=0x200.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared constants and types for the ADC channel consumers:
//                channel count/width, averaging FSM states, channel index.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_pkg;

    localparam int ADC_DW  = 12;
    localparam int ADC_NCH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    typedef logic [2:0] ch_idx_t;

endpackage
`default_nettype wire

// File: rtl/adc_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : adc_tick_gen
//  Description : Free-running divider producing a one-cycle TICK every
//                CLK_DIV clocks. The tick cycle is the one where the counter
//                sits at CLK_DIV-1; the counter is 0 in the first cycle
//                after reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_tick_gen #(
    parameter int CLK_DIV = 5000
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic TICK
);

    localparam int c_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    // Count 0..CLK_DIV-1 and wrap.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign TICK = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/adc_chan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_chan_avg
//  Description : Snapshots eight ADC channel words on each sample tick,
//                block-averages 2^LOG2_AVG snapshots per channel and keeps
//                sticky per-channel overcurrent flags against TRIP_LEVEL.
//                Channels are processed serially, one per cycle, after the
//                snapshot is taken.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_chan_avg
    import adc_pkg::*;
#(
    parameter int CLK_DIV  = 5000,
    parameter int LOG2_AVG = 4,
    parameter int DW       = ADC_DW
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [DW-1:0]        CH0,
    input  logic [DW-1:0]        CH1,
    input  logic [DW-1:0]        CH2,
    input  logic [DW-1:0]        CH3,
    input  logic [DW-1:0]        CH4,
    input  logic [DW-1:0]        CH5,
    input  logic [DW-1:0]        CH6,
    input  logic [DW-1:0]        CH7,
    input  logic [DW-1:0]        TRIP_LEVEL,
    input  logic                 CLEAR_ALARM,
    output logic [DW-1:0]        AVG0,
    output logic [DW-1:0]        AVG1,
    output logic [DW-1:0]        AVG2,
    output logic [DW-1:0]        AVG3,
    output logic [DW-1:0]        AVG4,
    output logic [DW-1:0]        AVG5,
    output logic [DW-1:0]        AVG6,
    output logic [DW-1:0]        AVG7,
    output logic                 AVG_VALID,
    output logic [ADC_NCH-1:0]   ALARM
);

    // Accumulator is wide enough for 2^LOG2_AVG full-scale samples.
    localparam int      c_AW       = DW + LOG2_AVG;
    localparam ch_idx_t c_LAST_IDX = ch_idx_t'(ADC_NCH - 1);

    logic               w_tick;
    logic [DW-1:0]      w_ch   [ADC_NCH];
    logic [ADC_NCH-1:0] w_set;

    state_t              r_state;
    ch_idx_t             r_idx;
    logic [LOG2_AVG-1:0] r_smp;
    logic [DW-1:0]       r_snap [ADC_NCH];
    logic [c_AW-1:0]     r_acc  [ADC_NCH];
    logic [DW-1:0]       r_avg  [ADC_NCH];
    logic                r_avg_valid;
    logic [ADC_NCH-1:0]  r_alarm;

    adc_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .TICK  (w_tick)
    );

    assign w_ch[0] = CH0;
    assign w_ch[1] = CH1;
    assign w_ch[2] = CH2;
    assign w_ch[3] = CH3;
    assign w_ch[4] = CH4;
    assign w_ch[5] = CH5;
    assign w_ch[6] = CH6;
    assign w_ch[7] = CH7;

    // Snapshot, serial accumulate and block dump sequencing.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_smp       <= '0;
            r_avg_valid <= 1'b0;
            for (int k = 0; k < ADC_NCH; k++) begin
                r_snap[k] <= '0;
                r_acc[k]  <= '0;
                r_avg[k]  <= '0;
            end
        end else begin
            r_avg_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        for (int k = 0; k < ADC_NCH; k++) begin
                            r_snap[k] <= w_ch[k];
                        end
                        r_idx   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc[r_idx] <= r_acc[r_idx] + {{LOG2_AVG{1'b0}}, r_snap[r_idx]};
                    r_idx        <= r_idx + ch_idx_t'(1);
                    if (r_idx == c_LAST_IDX) begin
                        r_smp <= r_smp + LOG2_AVG'(1);
                        if (r_smp == {LOG2_AVG{1'b1}}) begin
                            r_state <= DUMP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DUMP: begin
                    for (int k = 0; k < ADC_NCH; k++) begin
                        r_avg[k] <= DW'(r_acc[k] >> LOG2_AVG);
                        r_acc[k] <= '0;
                    end
                    r_avg_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Overcurrent detect for the channel being accumulated this cycle.
    always_comb begin
        w_set = '0;
        if ((r_state == ACCUM) && (r_snap[r_idx] > TRIP_LEVEL)) begin
            w_set[r_idx] = 1'b1;
        end
    end

    // Sticky alarms; a fresh set survives a simultaneous clear.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_alarm <= '0;
        end else if (CLEAR_ALARM) begin
            r_alarm <= w_set;
        end else begin
            r_alarm <= r_alarm | w_set;
        end
    end

    assign AVG0      = r_avg[0];
    assign AVG1      = r_avg[1];
    assign AVG2      = r_avg[2];
    assign AVG3      = r_avg[3];
    assign AVG4      = r_avg[4];
    assign AVG5      = r_avg[5];
    assign AVG6      = r_avg[6];
    assign AVG7      = r_avg[7];
    assign AVG_VALID = r_avg_valid;
    assign ALARM     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_adc_chan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_chan_avg
//  Description : Self-checking bench for adc_chan_avg (CLK_DIV=20,
//                LOG2_AVG=2). A reference model tracks ticks by cycle count
//                since reset release, sums samples per block and applies the
//                compare/clear rules for the alarm flags.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_chan_avg;

    localparam int CLK_DIV  = 20;
    localparam int LOG2_AVG = 2;
    localparam int DW       = 12;
    localparam int NBLK     = 4;
    localparam int NCH      = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] ch [NCH];
    logic [DW-1:0] trip;
    logic          clr;
    logic [DW-1:0] avg_o [NCH];
    logic          avg_valid;
    logic [7:0]    alarm;

    always #5 clk = ~clk;

    adc_chan_avg #(
        .CLK_DIV  (CLK_DIV),
        .LOG2_AVG (LOG2_AVG),
        .DW       (DW)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .CH0         (ch[0]),
        .CH1         (ch[1]),
        .CH2         (ch[2]),
        .CH3         (ch[3]),
        .CH4         (ch[4]),
        .CH5         (ch[5]),
        .CH6         (ch[6]),
        .CH7         (ch[7]),
        .TRIP_LEVEL  (trip),
        .CLEAR_ALARM (clr),
        .AVG0        (avg_o[0]),
        .AVG1        (avg_o[1]),
        .AVG2        (avg_o[2]),
        .AVG3        (avg_o[3]),
        .AVG4        (avg_o[4]),
        .AVG5        (avg_o[5]),
        .AVG6        (avg_o[6]),
        .AVG7        (avg_o[7]),
        .AVG_VALID   (avg_valid),
        .ALARM       (alarm)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int         cyc;
    int         last_tick;
    int         pend_cycle;
    int         blk_n;
    int         blk_sum  [NCH];
    int         snap     [NCH];
    int         pend_avg [NCH];
    int         exp_avg  [NCH];
    logic       exp_valid;
    logic [7:0] exp_alarm;

    function automatic void model_reset();
        cyc        = 0;
        last_tick  = -100;
        pend_cycle = -1;
        blk_n      = 0;
        exp_valid  = 1'b0;
        exp_alarm  = 8'h00;
        for (int k = 0; k < NCH; k++) begin
            blk_sum[k]  = 0;
            snap[k]     = 0;
            pend_avg[k] = 0;
            exp_avg[k]  = 0;
        end
    endfunction

    // Advance one clock with the current inputs and update the model.
    task automatic tick_cycle();
        logic [7:0] set;
        logic [7:0] nxt;
        int         k;
        set = 8'h00;
        if (last_tick >= 0 && cyc > last_tick && cyc <= last_tick + NCH) begin
            k = cyc - last_tick - 1;
            if (snap[k] > int'(trip)) set[k] = 1'b1;
        end
        nxt = clr ? set : (exp_alarm | set);
        if (cyc % CLK_DIV == CLK_DIV - 1) begin
            last_tick = cyc;
            blk_n++;
            for (int j = 0; j < NCH; j++) begin
                snap[j]    = int'(ch[j]);
                blk_sum[j] += int'(ch[j]);
            end
            if (blk_n == NBLK) begin
                for (int j = 0; j < NCH; j++) begin
                    pend_avg[j] = blk_sum[j] / NBLK;
                    blk_sum[j]  = 0;
                end
                pend_cycle = cyc + 10;
                blk_n      = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_alarm = nxt;
        exp_valid = (cyc == pend_cycle);
        if (exp_valid) begin
            for (int j = 0; j < NCH; j++) exp_avg[j] = pend_avg[j];
        end
    endtask

    // Assert reset between clock edges (caller checks outputs).
    task automatic assert_reset();
        #2;
        rst = 1'b1;
        #1;
    endtask

    // Release reset mid-cycle; the following cycle is cycle 0.
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int k = 0; k < NCH; k++) ch[k] = v;
    endtask

    task automatic test_reset();
        set_all('0);
        trip = 12'hFFF;
        clr  = 1'b0;
        assert_reset();
        for (int k = 0; k < NCH; k++) begin
            total++;
            if (avg_o[k] !== 12'd0) begin
                bad++;
                $display("FAIL reset_avg%0d: got %0d want 0", k, avg_o[k]);
            end
        end
        total++;
        if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", avg_valid);
        end
        total++;
        if (alarm !== 8'h00) begin
            bad++;
            $display("FAIL reset_alarm: got %h want 00", alarm);
        end
        release_reset();
    endtask

    task automatic test_constant();
        assert_reset();
        release_reset();
        for (int k = 0; k < NCH; k++) ch[k] = DW'(100 * k + 5);
        trip = 12'hFFF;
        clr  = 1'b0;
        while (cyc < 172) begin
            tick_cycle();
            total++;
            if (avg_valid !== exp_valid) begin
                bad++;
                $display("FAIL const_valid cyc%0d: got %b want %b", cyc, avg_valid, exp_valid);
            end
            if (cyc == 89 || cyc == 169) begin
                total++;
                if (avg_valid !== 1'b1 || avg_o[0] !== 12'd5 || avg_o[7] !== 12'd705) begin
                    bad++;
                    $display("FAIL const_strobe cyc%0d: got v=%b a0=%0d a7=%0d want v=1 a0=5 a7=705",
                             cyc, avg_valid, avg_o[0], avg_o[7]);
                end
                for (int k = 1; k < NCH - 1; k++) begin
                    total++;
                    if (avg_o[k] !== DW'(100 * k + 5)) begin
                        bad++;
                        $display("FAIL const_avg%0d: got %0d want %0d", k, avg_o[k], 100 * k + 5);
                    end
                end
            end
        end
    endtask

    task automatic test_full_scale();
        assert_reset();
        release_reset();
        trip = 12'hFFF;
        clr  = 1'b0;
        while (cyc < 171) begin
            for (int k = 1; k < NCH; k++) ch[k] = DW'($urandom_range(0, 4095));
            if (cyc % CLK_DIV == CLK_DIV - 1)
                ch[0] = (cyc / CLK_DIV == 3) ? 12'd4094 : 12'd4095;
            else
                ch[0] = DW'($urandom_range(0, 4095));
            tick_cycle();
            if (exp_valid) begin
                for (int k = 0; k < NCH; k++) begin
                    total++;
                    if (avg_o[k] !== DW'(exp_avg[k])) begin
                        bad++;
                        $display("FAIL fs_avg%0d cyc%0d: got %0d want %0d", k, cyc, avg_o[k], exp_avg[k]);
                    end
                end
            end
            if (cyc == 89 || cyc == 169) begin
                total++;
                if (avg_o[0] !== ((cyc == 89) ? 12'd4094 : 12'd4095)) begin
                    bad++;
                    $display("FAIL fs_ch0 cyc%0d: got %0d want %0d", cyc, avg_o[0], (cyc == 89) ? 4094 : 4095);
                end
            end
        end
    endtask

    task automatic test_alarm();
        assert_reset();
        release_reset();
        set_all('0);
        trip  = 12'd3000;
        clr   = 1'b0;
        ch[3] = 12'd3000;
        while (cyc < 30) tick_cycle();
        total++;
        if (alarm !== 8'h00) begin
            bad++;
            $display("FAIL alarm_equal: got %h want 00", alarm);
        end
        ch[3] = 12'd3001;
        while (cyc < 50) tick_cycle();
        total++;
        if (alarm !== 8'h08) begin
            bad++;
            $display("FAIL alarm_above: got %h want 08", alarm);
        end
        ch[3] = 12'd0;
        while (cyc < 70) tick_cycle();
        total++;
        if (alarm !== 8'h08) begin
            bad++;
            $display("FAIL alarm_sticky: got %h want 08", alarm);
        end
        clr = 1'b1;
        tick_cycle();
        clr = 1'b0;
        total++;
        if (alarm !== 8'h00) begin
            bad++;
            $display("FAIL alarm_clear: got %h want 00", alarm);
        end
        ch[0] = 12'd3500;
        ch[3] = 12'd3500;
        while (cyc < 90) tick_cycle();
        total++;
        if (alarm !== 8'h09) begin
            bad++;
            $display("FAIL alarm_two: got %h want 09", alarm);
        end
        ch[0] = 12'd0;
        ch[3] = 12'd0;
        ch[5] = 12'd4000;
        clr   = 1'b1;
        while (cyc < 106) begin
            tick_cycle();
            total++;
            if (alarm !== exp_alarm) begin
                bad++;
                $display("FAIL alarm_clrhold cyc%0d: got %h want %h", cyc, alarm, exp_alarm);
            end
        end
        total++;
        if (alarm !== 8'h20) begin
            bad++;
            $display("FAIL alarm_setwins: got %h want 20", alarm);
        end
        clr   = 1'b0;
        ch[5] = 12'd0;
        tick_cycle();
        total++;
        if (alarm !== 8'h20) begin
            bad++;
            $display("FAIL alarm_after: got %h want 20", alarm);
        end
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset();
        trip = 12'd1000;
        clr  = 1'b0;
        while (cyc < 125) begin
            for (int k = 0; k < NCH; k++) ch[k] = DW'($urandom_range(1500, 4095));
            tick_cycle();
        end
        assert_reset();
        total++;
        if (avg_valid !== 1'b0 || alarm !== 8'h00 || avg_o[0] !== 12'd0 || avg_o[7] !== 12'd0) begin
            bad++;
            $display("FAIL midreset_zero: got v=%b al=%h a0=%0d a7=%0d want all 0",
                     avg_valid, alarm, avg_o[0], avg_o[7]);
        end
        release_reset();
        trip = 12'hFFF;
        while (cyc < 91) begin
            for (int k = 0; k < NCH; k++) ch[k] = DW'($urandom_range(0, 4095));
            tick_cycle();
            total++;
            if (avg_valid !== exp_valid) begin
                bad++;
                $display("FAIL midreset_valid cyc%0d: got %b want %b", cyc, avg_valid, exp_valid);
            end
            if (cyc == 89) begin
                for (int k = 0; k < NCH; k++) begin
                    total++;
                    if (avg_o[k] !== DW'(exp_avg[k])) begin
                        bad++;
                        $display("FAIL midreset_avg%0d: got %0d want %0d", k, avg_o[k], exp_avg[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_toggle();
        assert_reset();
        release_reset();
        trip = 12'h200;
        clr  = 1'b0;
        while (cyc < 91) begin
            if (cyc % CLK_DIV == CLK_DIV - 1)
                set_all(12'h123);
            else
                for (int k = 0; k < NCH; k++) ch[k] = DW'($urandom_range(0, 4095));
            tick_cycle();
        end
        for (int k = 0; k < NCH; k++) begin
            total++;
            if (avg_o[k] !== 12'h123) begin
                bad++;
                $display("FAIL toggle_avg%0d: got %h want 123", k, avg_o[k]);
            end
        end
        total++;
        if (alarm !== 8'h00) begin
            bad++;
            $display("FAIL toggle_alarm: got %h want 00", alarm);
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        trip = DW'($urandom_range(1000, 4000));
        clr  = 1'b0;
        while (cyc < 500) begin
            for (int k = 0; k < NCH; k++) ch[k] = DW'($urandom_range(0, 4095));
            if ($urandom_range(0, 31) == 0) trip = DW'($urandom_range(1000, 4095));
            clr = ($urandom_range(0, 15) == 0);
            tick_cycle();
            total++;
            if (avg_valid !== exp_valid) begin
                bad++;
                $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, avg_valid, exp_valid);
            end
            total++;
            if (alarm !== exp_alarm) begin
                bad++;
                $display("FAIL rand_alarm cyc%0d: got %h want %h", cyc, alarm, exp_alarm);
            end
            for (int k = 0; k < NCH; k++) begin
                total++;
                if (avg_o[k] !== DW'(exp_avg[k])) begin
                    bad++;
                    $display("FAIL rand_avg%0d cyc%0d: got %0d want %0d", k, cyc, avg_o[k], exp_avg[k]);
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_constant();
        test_full_scale();
        test_alarm();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
